// File: rtl/leros_decode_if.sv
// Bus between the Leros fetch/decode sequencer and its surroundings:
// instruction ROM, register RAM and the accumulator ALU.
interface leros_decode_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8
) ();
    logic              run;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_rdata;
    logic [7:0]        dmem_addr;
    logic [DATA_W-1:0] dmem_rdata;
    logic [DATA_W-1:0] accu;
    logic [2:0]        op;
    logic [DATA_W-1:0] din;
    logic              ena;
    logic [PC_W-1:0]   pc;
    logic              halted;
    logic              illegal;

    // Environment side: memories, ALU and the run control.
    modport master (
        output run, imem_rdata, dmem_rdata, accu,
        input  imem_addr, dmem_addr, op, din, ena, pc, halted, illegal
    );

    // Sequencer side.
    modport slave (
        input  run, imem_rdata, dmem_rdata, accu,
        output imem_addr, dmem_addr, op, din, ena, pc, halted, illegal
    );
endinterface

// File: rtl/leros_decode.sv
// Leros instruction fetch/decode sequencer. Walks FETCH -> DECODE ->
// (MEM) -> EXEC, driving one ALU enable pulse per ALU instruction and
// resolving branches against the current accumulator.
module leros_decode #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8
) (
    input  logic          clock,
    input  logic          reset,
    leros_decode_if.slave bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_REG, C_IMM, C_SHR, C_BR, C_BRZ, C_BRNZ, C_HALT
    } class_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [7:0]        dmemAddr_q, dmemAddr_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              ena_q, ena_d;

    logic [15:0]       curInstr;
    logic [7:0]        operand;
    class_t            instrClass;
    logic [2:0]        aluOp;
    logic              signExt;
    logic              isIllegal;
    logic [DATA_W-1:0] immValue;
    logic [PC_W-1:0]   branchTarget;

    // The instruction is only on the ROM bus during DECODE; later states use the latched copy.
    assign curInstr     = (state_q == S_DECODE) ? bus.imem_rdata : instr_q;
    assign operand      = curInstr[7:0];
    assign immValue     = signExt ? DATA_W'($signed(operand)) : DATA_W'(operand);
    assign branchTarget = pc_q + PC_W'($signed(operand));

    // Classify the opcode and pick the ALU operation and immediate extension.
    always_comb begin
        instrClass = C_NOP;
        aluOp      = 3'd0;
        signExt    = 1'b0;
        isIllegal  = 1'b0;
        case (curInstr[15:8])
            8'h00: instrClass = C_NOP;
            8'h08: begin instrClass = C_REG; aluOp = 3'd1; end
            8'h09: begin instrClass = C_IMM; aluOp = 3'd1; signExt = 1'b1; end
            8'h0C: begin instrClass = C_REG; aluOp = 3'd2; end
            8'h0D: begin instrClass = C_IMM; aluOp = 3'd2; signExt = 1'b1; end
            8'h10: begin instrClass = C_SHR; aluOp = 3'd6; end
            8'h20: begin instrClass = C_REG; aluOp = 3'd7; end
            8'h21: begin instrClass = C_IMM; aluOp = 3'd7; signExt = 1'b1; end
            8'h22: begin instrClass = C_REG; aluOp = 3'd3; end
            8'h23: begin instrClass = C_IMM; aluOp = 3'd3; end
            8'h24: begin instrClass = C_REG; aluOp = 3'd4; end
            8'h25: begin instrClass = C_IMM; aluOp = 3'd4; end
            8'h26: begin instrClass = C_REG; aluOp = 3'd5; end
            8'h27: begin instrClass = C_IMM; aluOp = 3'd5; end
            8'h40: instrClass = C_BR;
            8'h48: instrClass = C_BRZ;
            8'h49: instrClass = C_BRNZ;
            8'hFF: instrClass = C_HALT;
            default: isIllegal = 1'b1;
        endcase
    end

    // Next-state, PC and ALU-drive logic; op/din/ena only load on the edge into EXEC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        dmemAddr_d = dmemAddr_q;
        op_d       = 3'd0;
        din_d      = din_q;
        ena_d      = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.run) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                instr_d = bus.imem_rdata;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
                case (instrClass)
                    C_REG: begin
                        dmemAddr_d = operand;
                        state_d    = S_MEM;
                    end
                    C_IMM: begin
                        state_d = S_EXEC;
                        ena_d   = 1'b1;
                        op_d    = aluOp;
                        din_d   = immValue;
                    end
                    C_SHR: begin
                        state_d = S_EXEC;
                        ena_d   = 1'b1;
                        op_d    = aluOp;
                        din_d   = '0;
                    end
                    C_BR: pc_d = branchTarget;
                    C_BRZ: begin
                        if (bus.accu == '0) begin
                            pc_d = branchTarget;
                        end
                    end
                    C_BRNZ: begin
                        if (bus.accu != '0) begin
                            pc_d = branchTarget;
                        end
                    end
                    C_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                state_d = S_EXEC;
                ena_d   = 1'b1;
                op_d    = aluOp;
                din_d   = bus.dmem_rdata;
            end
            S_EXEC: state_d = S_FETCH;
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            instr_q    <= '0;
            dmemAddr_q <= '0;
            op_q       <= 3'd0;
            din_q      <= '0;
            ena_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            dmemAddr_q <= dmemAddr_d;
            op_q       <= op_d;
            din_q      <= din_d;
            ena_q      <= ena_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.dmem_addr = dmemAddr_q;
    assign bus.op        = op_q;
    assign bus.din       = din_q;
    assign bus.ena       = ena_q;
    assign bus.halted    = (state_q == S_HALT);
    assign bus.illegal   = (state_q == S_DECODE) && isIllegal;
endmodule
